// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter unit.
package pc_pkg;

  localparam int PC_WIDTH = 64;
  localparam int PC_INC   = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // Low address bits that must be zero for a legal word-aligned branch target.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_stage_reg.sv
// One shadow-pipeline slot: a PC register plus its valid bit.
module pc_stage_reg
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_pc,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_pc,
  output logic             q_valid
);

  // A flush only happens on a redirect, which always shifts, so clr is
  // folded into the shifted-in valid rather than acting on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_pc    <= d_pc;
      q_valid <= d_valid & ~clr;
    end
  end

endmodule

// File: rtl/pc_pipe.sv
// Fetch program counter with a shadow pipeline of per-stage PCs.
// Define PC_PIPE_ALIGN_CHECK_EN to trap misaligned branch targets (sticky misalign).
module pc_pipe
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC    = '0,
  parameter int               INC          = PC_INC,
  parameter int               STAGES       = 3,
  parameter int               FLUSH_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic [WIDTH-1:0]        br_target,
  output logic [WIDTH-1:0]        pc_out,
  output logic [WIDTH-1:0]        pc_plus_inc,
  output logic [STAGES*WIDTH-1:0] pc_stage,
  output logic [STAGES-1:0]       stage_valid,
  output logic                    misalign
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q;
  logic             frozen;
  logic             redirect;
  logic             advance;

`ifdef PC_PIPE_ALIGN_CHECK_EN
  logic fault;
  logic misalign_q;

  assign fault = br_taken & (|(br_target[1:0] & PC_ALIGN_MASK));

  always_ff @(posedge clk) begin
    if (reset)      misalign_q <= 1'b0;
    else if (fault) misalign_q <= 1'b1;
  end

  // The faulting cycle itself behaves as a stall; afterwards everything stays frozen.
  assign frozen   = misalign_q | fault;
  assign misalign = misalign_q;
`else
  assign frozen   = 1'b0;
  assign misalign = 1'b0;
`endif

  // Redirect beats stall; both shift the shadow pipeline.
  assign redirect = br_taken & ~frozen;
  assign advance  = redirect | (~stall & ~frozen);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks evaluate in.
  always_ff @(posedge clk) begin
    if (reset)         pc_q <= RESET_VEC;
    else if (redirect) pc_q <= br_target;
    else if (advance)  pc_q <= pc_q + INC_W;
  end

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_q + INC_W;

  logic [WIDTH-1:0] stage_pc [STAGES];
  logic             stage_v  [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] d_pc;
    logic             d_valid;

    if (i == 0) begin : g_head
      assign d_pc    = pc_q;
      assign d_valid = 1'b1;
    end else begin : g_tail
      assign d_pc    = stage_pc[i-1];
      assign d_valid = stage_v[i-1];
    end

    pc_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (advance),
      .clr     (redirect && (i < FLUSH_STAGES)),
      .d_pc    (d_pc),
      .d_valid (d_valid),
      .q_pc    (stage_pc[i]),
      .q_valid (stage_v[i])
    );

    assign pc_stage[i*WIDTH +: WIDTH] = stage_pc[i];
    assign stage_valid[i]             = stage_v[i];
  end

endmodule

// File: tb/tb_pc_pipe.sv
// Scoreboard bench for pc_pipe: directed steps push expected state, a monitor compares each cycle.
module tb_pc_pipe;
  import pc_pkg::*;

  localparam pc_t M8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam pc_t M4 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, br_taken;
  pc_t  br_target;

  pc_t          pc_out_a, inc_a, pc_out_b, inc_b;
  logic [191:0] stage_a, stage_b;
  logic [2:0]   valid_a, valid_b;
  logic         mis_a, mis_b;

  pc_pipe #(.WIDTH(64), .RESET_VEC(64'd0), .INC(4), .STAGES(3), .FLUSH_STAGES(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .pc_out(pc_out_a), .pc_plus_inc(inc_a), .pc_stage(stage_a), .stage_valid(valid_a),
    .misalign(mis_a)
  );

  pc_pipe #(.WIDTH(64), .RESET_VEC(M8), .INC(4), .STAGES(3), .FLUSH_STAGES(2)) dut_hi (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .pc_out(pc_out_b), .pc_plus_inc(inc_b), .pc_stage(stage_b), .stage_valid(valid_b),
    .misalign(mis_b)
  );

  typedef struct {
    logic       sel;
    pc_t        pc;
    pc_t        s0;
    pc_t        s1;
    pc_t        s2;
    logic [2:0] v;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   step_no     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input pc_t t, input logic sel,
                      input pc_t epc, input pc_t s0, input pc_t s1, input pc_t s2,
                      input logic [2:0] ev, input logic em);
    reset     = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    exp_q.push_back('{sel, epc, s0, s1, s2, ev, em});
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock, sampled just after the edge that produced it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        if (!e.sel) begin
          check($sformatf("s%0d pc_out", step_no), pc_out_a, e.pc);
          check($sformatf("s%0d pc_plus_inc", step_no), inc_a, e.pc + 64'd4);
          check($sformatf("s%0d stage0", step_no), stage_a[63:0], e.s0);
          check($sformatf("s%0d stage1", step_no), stage_a[127:64], e.s1);
          check($sformatf("s%0d stage2", step_no), stage_a[191:128], e.s2);
          check($sformatf("s%0d valid", step_no), 64'(valid_a), 64'(e.v));
          check($sformatf("s%0d misalign", step_no), 64'(mis_a), 64'(e.mis));
        end else begin
          check($sformatf("s%0d hi pc_out", step_no), pc_out_b, e.pc);
          check($sformatf("s%0d hi pc_plus_inc", step_no), inc_b, e.pc + 64'd4);
          check($sformatf("s%0d hi stage0", step_no), stage_b[63:0], e.s0);
          check($sformatf("s%0d hi stage1", step_no), stage_b[127:64], e.s1);
          check($sformatf("s%0d hi stage2", step_no), stage_b[191:128], e.s2);
          check($sformatf("s%0d hi valid", step_no), 64'(valid_b), 64'(e.v));
          check($sformatf("s%0d hi misalign", step_no), 64'(mis_b), 64'(e.mis));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //    rst  stl  br   target   sel  pc       s0       s1       s2       v       mis
    step(1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   64'h0,   64'h0,   64'h0,   3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   64'h0,   64'h0,   64'h0,   3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h4,   64'h0,   64'h0,   64'h0,   3'b001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h8,   64'h4,   64'h0,   64'h0,   3'b011, 1'b0);
    step(1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h8,   64'h4,   64'h0,   64'h0,   3'b011, 1'b0);
    step(1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h8,   64'h4,   64'h0,   64'h0,   3'b011, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'hC,   64'h8,   64'h4,   64'h0,   3'b111, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h10,  64'hC,   64'h8,   64'h4,   3'b111, 1'b0);
    // redirect squashes the two youngest stages
    step(1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 64'h100, 64'h10,  64'hC,   64'h8,   3'b100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h104, 64'h100, 64'h10,  64'hC,   3'b001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h108, 64'h104, 64'h100, 64'h10,  3'b011, 1'b0);
    // redirect beats a simultaneous stall
    step(1'b0, 1'b1, 1'b1, 64'h200, 1'b0, 64'h200, 64'h108, 64'h104, 64'h100, 3'b100, 1'b0);
    step(1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h200, 64'h108, 64'h104, 64'h100, 3'b100, 1'b0);
    // back-to-back redirects
    step(1'b0, 1'b0, 1'b1, 64'h300, 1'b0, 64'h300, 64'h200, 64'h108, 64'h104, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h400, 1'b0, 64'h400, 64'h300, 64'h200, 64'h108, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h404, 64'h400, 64'h300, 64'h200, 3'b001, 1'b0);
    // reset overrides stall and redirect together
    step(1'b1, 1'b1, 1'b1, 64'h500, 1'b0, 64'h0,   64'h0,   64'h0,   64'h0,   3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h4,   64'h0,   64'h0,   64'h0,   3'b001, 1'b0);
`ifdef PC_PIPE_ALIGN_CHECK_EN
    step(1'b0, 1'b0, 1'b1, 64'h102, 1'b0, 64'h4,   64'h0,   64'h0,   64'h0,   3'b001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h4,   64'h0,   64'h0,   64'h0,   3'b001, 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h600, 1'b0, 64'h4,   64'h0,   64'h0,   64'h0,   3'b001, 1'b1);
`else
    step(1'b0, 1'b0, 1'b1, 64'h102, 1'b0, 64'h102, 64'h4,   64'h0,   64'h0,   3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h106, 64'h102, 64'h4,   64'h0,   3'b001, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h600, 1'b0, 64'h600, 64'h106, 64'h102, 64'h4,   3'b000, 1'b0);
`endif
    step(1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   64'h0,   64'h0,   64'h0,   3'b000, 1'b0);
    // high reset vector wraps through zero with no flag
    step(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, M8,      64'h0,   64'h0,   64'h0,   3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b1, M4,      M8,      64'h0,   64'h0,   3'b001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h0,   M4,      M8,      64'h0,   3'b011, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h4,   64'h0,   M4,      M8,      3'b111, 1'b0);

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
